// File: rtl/sap_controller.sv
// SAP-1 control sequencer: a one-hot T1..T6 ring decoded with the IR opcode into
// bus/register strobes. At most one DATA driver is enabled per cycle, and HLT halts the ring.
module sap_controller #(
  parameter logic [3:0] OP_LDA      = 4'h0,
  parameter logic [3:0] OP_ADD      = 4'h1,
  parameter logic [3:0] OP_SUB      = 4'h2,
  parameter logic [3:0] OP_OUT      = 4'hE,
  parameter logic [3:0] OP_HLT      = 4'hF,
  parameter bit         SHORT_CYCLE = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic [3:0] opcode,
  output logic       pc_inc,
  output logic       pc_en,
  output logic       mar_latch,
  output logic       ram_en,
  output logic       ir_latch,
  output logic       ir_en,
  output logic       a_latch,
  output logic       a_en,
  output logic       b_latch,
  output logic       alu_sub,
  output logic       alu_en,
  output logic       out_latch,
  output logic [5:0] t_state,
  output logic       halted
);

  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } ring_e;

  ring_e state, state_next;
  logic  halted_next;
  logic  advance;
  logic  is_lda, is_add, is_sub, is_out, is_hlt, is_nop;

  assign is_lda  = (opcode == OP_LDA);
  assign is_add  = (opcode == OP_ADD);
  assign is_sub  = (opcode == OP_SUB);
  assign is_out  = (opcode == OP_OUT);
  assign is_hlt  = (opcode == OP_HLT);
  assign is_nop  = !(is_lda || is_add || is_sub || is_out || is_hlt);
  assign advance = run && !halted;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= T1;
      halted <= 1'b0;
    end else begin
      state  <= state_next;
      halted <= halted_next;
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_next  = state;
    halted_next = halted;
    case (state)
      T1: if (advance) state_next = T2;
      T2: if (advance) state_next = T3;
      T3: if (advance) state_next = T4;
      T4: if (advance) begin
        if (is_hlt)                                state_next = T4;
        else if (SHORT_CYCLE && (is_out || is_nop)) state_next = T1;
        else                                       state_next = T5;
        if (is_hlt) halted_next = 1'b1;
      end
      T5: if (advance) state_next = (SHORT_CYCLE && is_lda) ? T1 : T6;
      T6: if (advance) state_next = T1;
      // Unreachable illegal encodings fall back to T1 regardless of run.
      default: state_next = T1;
    endcase
  end

  always_comb begin
    pc_inc    = 1'b0;
    pc_en     = 1'b0;
    mar_latch = 1'b0;
    ram_en    = 1'b0;
    ir_latch  = 1'b0;
    ir_en     = 1'b0;
    a_latch   = 1'b0;
    a_en      = 1'b0;
    b_latch   = 1'b0;
    alu_sub   = 1'b0;
    alu_en    = 1'b0;
    out_latch = 1'b0;
    if (reset && advance) begin
      case (state)
        T1: begin pc_en = 1'b1; mar_latch = 1'b1; end
        T2: pc_inc = 1'b1;
        T3: begin ram_en = 1'b1; ir_latch = 1'b1; end
        T4: begin
          if (is_lda || is_add || is_sub) begin
            ir_en     = 1'b1;
            mar_latch = 1'b1;
          end else if (is_out) begin
            a_en      = 1'b1;
            out_latch = 1'b1;
          end
        end
        T5: begin
          if (is_lda) begin
            ram_en  = 1'b1;
            a_latch = 1'b1;
          end else if (is_add || is_sub) begin
            ram_en  = 1'b1;
            b_latch = 1'b1;
          end
        end
        T6: begin
          if (is_add || is_sub) begin
            alu_en  = 1'b1;
            a_latch = 1'b1;
            alu_sub = is_sub;
          end
        end
        default: ;
      endcase
    end
  end

  assign t_state = state;

endmodule

// File: tb/tb_sap_controller.sv
// Self-checking bench for sap_controller: two instances (SHORT_CYCLE 0 and 1) share
// stimulus and are compared against a step-number reference model.
module tb_sap_controller;

  logic       clk = 1'b0;
  logic       reset, run;
  logic [3:0] opcode;

  logic [11:0] strb [2];
  logic [5:0]  ts   [2];
  logic        hlt  [2];

  // Strobe vector bit positions.
  localparam int PC_INC = 11, PC_EN = 10, MAR_L = 9, RAM_EN = 8, IR_L = 7, IR_EN = 6,
                 A_L = 5, A_EN = 4, B_L = 3, ALU_SUB = 2, ALU_EN = 1, OUT_L = 0;
  localparam logic [11:0] BUS_MASK = 12'b0101_0101_0010;

  always #5 clk = ~clk;

  sap_controller #(.SHORT_CYCLE(1'b0)) dut0 (
    .clk(clk), .reset(reset), .run(run), .opcode(opcode),
    .pc_inc(strb[0][11]), .pc_en(strb[0][10]), .mar_latch(strb[0][9]), .ram_en(strb[0][8]),
    .ir_latch(strb[0][7]), .ir_en(strb[0][6]), .a_latch(strb[0][5]), .a_en(strb[0][4]),
    .b_latch(strb[0][3]), .alu_sub(strb[0][2]), .alu_en(strb[0][1]), .out_latch(strb[0][0]),
    .t_state(ts[0]), .halted(hlt[0]));

  sap_controller #(.SHORT_CYCLE(1'b1)) dut1 (
    .clk(clk), .reset(reset), .run(run), .opcode(opcode),
    .pc_inc(strb[1][11]), .pc_en(strb[1][10]), .mar_latch(strb[1][9]), .ram_en(strb[1][8]),
    .ir_latch(strb[1][7]), .ir_en(strb[1][6]), .a_latch(strb[1][5]), .a_en(strb[1][4]),
    .b_latch(strb[1][3]), .alu_sub(strb[1][2]), .alu_en(strb[1][1]), .out_latch(strb[1][0]),
    .t_state(ts[1]), .halted(hlt[1]));

  // Reference model: current T-step (1..6) and halt flag per instance.
  int m_step [2];
  bit m_halt [2];
  int checks = 0;
  int fails  = 0;

  function automatic logic [11:0] exp_strobes(int step, logic [3:0] op, bit rn, bit rs, bit h);
    logic [11:0] s = '0;
    if (!rs || !rn || h) return s;
    case (step)
      1: begin s[PC_EN] = 1; s[MAR_L] = 1; end
      2: s[PC_INC] = 1;
      3: begin s[RAM_EN] = 1; s[IR_L] = 1; end
      4: if (op == 4'h0 || op == 4'h1 || op == 4'h2) begin s[IR_EN] = 1; s[MAR_L] = 1; end
         else if (op == 4'hE) begin s[A_EN] = 1; s[OUT_L] = 1; end
      5: if (op == 4'h0) begin s[RAM_EN] = 1; s[A_L] = 1; end
         else if (op == 4'h1 || op == 4'h2) begin s[RAM_EN] = 1; s[B_L] = 1; end
      6: if (op == 4'h1 || op == 4'h2) begin s[ALU_EN] = 1; s[A_L] = 1; s[ALU_SUB] = (op == 4'h2); end
      default: ;
    endcase
    return s;
  endfunction

  // Last active step of an instruction when the short cycle is enabled.
  function automatic int last_step(logic [3:0] op);
    if (op == 4'h0) return 5;
    if (op == 4'h1 || op == 4'h2 || op == 4'hF) return 6;
    return 4;
  endfunction

  task automatic check_vec(string tag, logic [11:0] obs, logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    for (int i = 0; i < 2; i++) begin
      check_vec($sformatf("strobes[%0d]", i), strb[i],
                exp_strobes(m_step[i], opcode, run, reset, m_halt[i]));
      check_vec($sformatf("t_state[%0d]", i), {6'b0, ts[i]}, 12'(1 << (m_step[i] - 1)));
      check_vec($sformatf("halted[%0d]", i), {11'b0, hlt[i]}, {11'b0, m_halt[i]});
      checks++;
      assert ($onehot0(strb[i] & BUS_MASK)) else begin
        fails++;
        $error("FAIL bus_excl[%0d] observed=%b expected=at most one enable", i, strb[i] & BUS_MASK);
      end
    end
  endtask

  // Check current outputs, take one clock edge, advance the model with the sampled inputs.
  task automatic tick();
    #1 check_outputs();
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (!reset) begin
        m_step[i] = 1;
        m_halt[i] = 0;
      end else if (run && !m_halt[i]) begin
        if (m_step[i] == 4 && opcode == 4'hF)             m_halt[i] = 1;
        else if (i == 1 && m_step[i] == last_step(opcode)) m_step[i] = 1;
        else                                             m_step[i] = (m_step[i] == 6) ? 1 : m_step[i] + 1;
      end
    end
    #1;
  endtask

  task automatic ticks(int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic do_reset(int n);
    reset = 1'b0;
    ticks(n);
    reset = 1'b1;
  endtask

  initial begin
    m_step = '{1, 1};
    m_halt = '{0, 0};
    reset  = 1'b0;
    run    = 1'b1;
    opcode = 4'h0;
    @(posedge clk); #1;

    // Reset then a full LDA instruction on both variants.
    do_reset(2);
    run = 1'b1; opcode = 4'h0;
    ticks(7);

    // SUB with six-cycle sequencing; alu_sub only in T6.
    do_reset(1);
    opcode = 4'h2;
    ticks(7);

    // HLT: latch halt at T4, stay frozen, clear on reset.
    do_reset(1);
    opcode = 4'hF;
    ticks(24);
    do_reset(1);
    ticks(1);

    // run dropped during T2 for five cycles, then resumed.
    do_reset(1);
    opcode = 4'h0;
    ticks(1);
    run = 1'b0;
    ticks(5);
    run = 1'b1;
    ticks(3);

    // Short cycle: OUT then LDA.
    do_reset(1);
    opcode = 4'hE;
    ticks(4);
    opcode = 4'h0;
    ticks(5);

    // Reset asserted at T5 of ADD.
    do_reset(1);
    opcode = 4'h1;
    ticks(4);
    do_reset(1);
    ticks(2);

    // HLT decode with run low at T4: no halt until run returns.
    do_reset(1);
    opcode = 4'hF;
    ticks(3);
    run = 1'b0;
    ticks(3);
    run = 1'b1;
    ticks(3);

    // Randomized opcode/run/reset traffic.
    do_reset(1);
    for (int k = 0; k < 400; k++) begin
      case ($urandom_range(0, 7))
        0: opcode = 4'h0;
        1: opcode = 4'h1;
        2: opcode = 4'h2;
        3: opcode = 4'hE;
        4: opcode = ($urandom_range(0, 3) == 0) ? 4'hF : 4'h1;
        default: opcode = 4'($urandom_range(0, 15));
      endcase
      run   = ($urandom_range(0, 5) != 0);
      reset = ($urandom_range(0, 30) != 0);
      tick();
    end
    reset = 1'b1;
    ticks(1);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
